// File: rtl/ppa_pkg.sv
// Shared types and constants for the parallel-prefix adder/subtractor family.
package ppa_pkg;

  localparam int unsigned PPA_W   = 16;
  localparam int unsigned PPA_LVL = $clog2(PPA_W);

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  typedef pg_t [PPA_W-1:0] pg_vec_t;

  // Brent-Kung up-sweep: after level l, node i with (i+1) % 2^l == 0 covers bits [i-2^l+1:i].
  function automatic pg_vec_t bk_up_sweep(input pg_vec_t v);
    pg_vec_t r;
    r = v;
    for (int l = 1; l <= int'(PPA_LVL); l++) begin
      for (int i = 0; i < int'(PPA_W); i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          r[i].g = r[i].g | (r[i].p & r[i - (1 << (l - 1))].g);
          r[i].p = r[i].p & r[i - (1 << (l - 1))].p;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppa_black.sv
// Prefix black cell: combines a high group (i) with the adjacent low group (j).
module ppa_black (
  input  logic pi_i,
  input  logic gi_i,
  input  logic pj_i,
  input  logic gj_i,
  output logic p_o,
  output logic g_o
);
  assign p_o = pi_i & pj_i;
  assign g_o = gi_i | (pi_i & gj_i);
endmodule

// File: rtl/ppa_grey.sv
// Prefix grey cell: generate-only combine, used where the group propagate is no longer needed.
module ppa_grey (
  input  logic pi_i,
  input  logic gi_i,
  input  logic gj_i,
  output logic g_o
);
  assign g_o = gi_i | (pi_i & gj_i);
endmodule

// File: rtl/ppa_pipe_reg.sv
// Register slice with valid bit; loads only when enabled, async active-high clear.
module ppa_pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Stage register: advances as a whole on en_i, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ppa_post.sv
// Sum cell: bit propagate XOR incoming carry.
module ppa_post (
  input  logic p_i,
  input  logic c_i,
  output logic s_o
);
  assign s_o = p_i ^ c_i;
endmodule

// File: rtl/ppa_pre.sv
// Bit-level propagate/generate pre-processing cell.
module ppa_pre (
  input  logic a_i,
  input  logic b_i,
  output logic p_o,
  output logic g_o
);
  assign p_o = a_i ^ b_i;
  assign g_o = a_i & b_i;
endmodule

// File: rtl/ppa_sub_pipe16.sv
// Three-stage Brent-Kung subtractor: diff = a + ~b + ~bin, with borrow/overflow/zero flags.
module ppa_sub_pipe16
  import ppa_pkg::*;
#(
  parameter int unsigned WIDTH = PPA_W,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LVL = $clog2(WIDTH);
  localparam int unsigned S1W = 2 * WIDTH + 2 + TAG_W;
  localparam int unsigned S2W = 3 * WIDTH + 2 + TAG_W;
  localparam int unsigned S3W = WIDTH + 3 + TAG_W;

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------- S1: bit pre-processing against ~b ----------------
  logic [WIDTH-1:0] pre_p, pre_g;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pre
    ppa_pre u_pre (.a_i(a[i]), .b_i(~b[i]), .p_o(pre_p[i]), .g_o(pre_g[i]));
  end

  logic [S1W-1:0]   s1_d, s1_q;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_cin, s1_amsb;
  logic [TAG_W-1:0] s1_tag;

  assign s1_d = {pre_p, pre_g, ~bin, a[WIDTH-1], in_tag};

  ppa_pipe_reg #(.WIDTH(S1W)) u_s1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(in_valid),
    .data_i(s1_d), .valid_o(s1_valid), .data_o(s1_q)
  );

  assign {s1_p, s1_g, s1_cin, s1_amsb, s1_tag} = s1_q;

  // ---------------- S1 -> S2: up-sweep ----------------
  // Carry-in is folded into bit 0 so every prefix G is directly the carry out of that bit.
  logic g0_cin;
  ppa_grey u_cin (.pi_i(s1_p[0]), .gi_i(s1_g[0]), .gj_i(s1_cin), .g_o(g0_cin));

  for (genvar l = 0; l <= LVL; l++) begin : g_up
    logic [WIDTH-1:0] p, g;
    if (l == 0) begin : g_base
      assign p = s1_p;
      assign g = {s1_g[WIDTH-1:1], g0_cin};
    end else begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (1 << l)) == 0) begin : g_node
          ppa_black u_blk (
            .pi_i(g_up[l-1].p[i]), .gi_i(g_up[l-1].g[i]),
            .pj_i(g_up[l-1].p[i-(1<<(l-1))]), .gj_i(g_up[l-1].g[i-(1<<(l-1))]),
            .p_o(p[i]), .g_o(g[i])
          );
        end else begin : g_pass
          assign p[i] = g_up[l-1].p[i];
          assign g[i] = g_up[l-1].g[i];
        end
      end
    end
  end

  logic [S2W-1:0]   s2_d, s2_q;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_up_p, s2_up_g, s2_p;
  logic             s2_cin, s2_amsb;
  logic [TAG_W-1:0] s2_tag;

  assign s2_d = {g_up[LVL].p, g_up[LVL].g, s1_p, s1_cin, s1_amsb, s1_tag};

  ppa_pipe_reg #(.WIDTH(S2W)) u_s2 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(s1_valid),
    .data_i(s2_d), .valid_o(s2_valid), .data_o(s2_q)
  );

  assign {s2_up_p, s2_up_g, s2_p, s2_cin, s2_amsb, s2_tag} = s2_q;

  // Only the group propagates feeding grey cells are consumed downstream.
  logic unused_up_p;
  assign unused_up_p = ^s2_up_p;

  // ---------------- S2 -> S3: down-sweep, sum and flags ----------------
  for (genvar k = 0; k < LVL; k++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (k == 0) begin : g_base
      assign g = s2_up_g;
    end else begin : g_lvl
      localparam int Step = 1 << (LVL - k);
      localparam int Half = Step / 2;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % Step) == Half) && (i >= Step)) begin : g_node
          ppa_grey u_gry (
            .pi_i(s2_up_p[i]), .gi_i(g_dn[k-1].g[i]), .gj_i(g_dn[k-1].g[i-Half]), .g_o(g[i])
          );
        end else begin : g_pass
          assign g[i] = g_dn[k-1].g[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] gf, carry, sum;
  assign gf    = g_dn[LVL-1].g;
  assign carry = {gf[WIDTH-2:0], s2_cin};

  for (genvar i = 0; i < WIDTH; i++) begin : g_post
    ppa_post u_post (.p_i(s2_p[i]), .c_i(carry[i]), .s_o(sum[i]));
  end

  logic [S3W-1:0] s3_d, s3_q;
  // p[MSB] = a ^ ~b is 0 exactly when the operand signs differ.
  assign s3_d = {sum, ~gf[WIDTH-1], ~s2_p[WIDTH-1] & (sum[WIDTH-1] ^ s2_amsb), ~|sum, s2_tag};

  ppa_pipe_reg #(.WIDTH(S3W)) u_s3 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(s2_valid),
    .data_i(s3_d), .valid_o(out_valid), .data_o(s3_q)
  );

  assign {diff, bout, ovf, zero, out_tag} = s3_q;

endmodule

// File: tb/tb_ppa_sub_pipe16.sv
// Scoreboard bench for ppa_sub_pipe16 against an integer-arithmetic reference model.
module tb_ppa_sub_pipe16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf, zero;
  logic [15:0] a, b, diff;
  logic [3:0]  in_tag, out_tag;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  res_t exp_q[$];
  int   pop_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   cyc = 0;

  ppa_sub_pipe16 #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .bin(bin),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout),
    .ovf(ovf), .zero(zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mbin, input logic [3:0] mtag);
    res_t e;
    int   r, s;
    r = int'(ma) - int'(mb) - int'(mbin);
    s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    e.diff = r[15:0];
    e.bout = (r < 0);
    e.ovf  = (s > 32767) || (s < -32768);
    e.zero = (e.diff == 16'h0000);
    e.tag  = mtag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Input side: an accepted operation pushes its expected result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, bin, in_tag));
      acc_cnt++;
    end
  end

  // Output side: every output handshake pops and compares.
  always @(negedge clk) begin : mon
    res_t e, got;
    if (!rst && out_valid && out_ready) begin
      total++;
      got = {diff, bout, ovf, zero, out_tag};
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got diff=%h bout=%b ovf=%b zero=%b tag=%h, required none",
                 diff, bout, ovf, zero, out_tag);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          begin
            bad++;
            $display("FAIL result: got diff=%h bout=%b ovf=%b zero=%b tag=%h, required diff=%h bout=%b ovf=%b zero=%b tag=%h",
                     diff, bout, ovf, zero, out_tag, e.diff, e.bout, e.ovf, e.zero, e.tag);
          end
      end
    end
  end

  task automatic set_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        input logic [3:0] ttag);
    a = ta; b = tb; bin = tbin; in_tag = ttag; in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic drive_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          input logic [3:0] ttag);
    logic took;
    took = 1'b0;
    set_op(ta, tb, tbin, ttag);
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept_in_time", {31'd0, took}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic rand_op(output logic [15:0] ra, output logic [15:0] rb, output logic rbin);
    int mode;
    mode = $urandom_range(0, 7);
    ra   = 16'($urandom);
    rb   = 16'($urandom);
    rbin = 1'($urandom);
    case (mode)
      0: rb = ra;
      1: begin ra = 16'h0000; rb = 16'hFFFF; end
      2: begin ra = 16'h8000; rb = 16'($urandom_range(0, 1)); end
      3: begin ra = 16'h7FFF; rb = 16'hFFFF - 16'($urandom_range(0, 1)); end
      default: ;
    endcase
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] ra, rb;
    logic        rbin, took;
    res_t        hold_exp;
    int          acc0, nops, guard;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {10'd0, diff, bout, ovf, zero, out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: driven after edge N, accepted at N+1, valid from N+3.
    @(posedge clk);
    #1 set_op(16'h0000, 16'h0001, 1'b0, 4'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk) chk("lat_n1", {31'd0, out_valid}, 32'd0);
    @(negedge clk) chk("lat_n2", {31'd0, out_valid}, 32'd0);
    @(negedge clk) chk("lat_n3", {31'd0, out_valid}, 32'd1);
    chk("dir0_diff", {16'd0, diff}, 32'h0000_FFFF);
    chk("dir0_flags", {29'd0, bout, ovf, zero}, 32'd4);
    @(posedge clk);
    #1;

    // Boundary vectors, back-to-back.
    drive_op(16'h8000, 16'h0001, 1'b0, 4'h2);
    drive_op(16'h1234, 16'h1234, 1'b0, 4'h3);
    drive_op(16'h0005, 16'h0003, 1'b1, 4'h4);
    drive_op(16'h0000, 16'hFFFF, 1'b1, 4'h5);
    drive_op(16'h0000, 16'h0000, 1'b1, 4'h6);
    drive_op(16'h7FFF, 16'h8000, 1'b0, 4'h7);
    in_valid = 1'b0;
    wait_drain();

    // Streaming: 8 ops back-to-back must emerge on consecutive cycles.
    pop_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      rand_op(ra, rb, rbin);
      drive_op(ra, rb, rbin, 4'(k));
    end
    in_valid = 1'b0;
    wait_drain();
    chk("stream_count", pop_cyc.size(), 32'd8);
    for (int k = 1; k < pop_cyc.size(); k++)
      chk("stream_consecutive", pop_cyc[k] - pop_cyc[k-1], 32'd1);

    // Backpressure: 6 stalled cycles accept exactly 3 ops and hold the head result.
    out_ready = 1'b0;
    acc0 = acc_cnt;
    rand_op(ra, rb, rbin);
    set_op(ra, rb, rbin, 4'h9);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = in_ready;
      if (c >= 3) begin
        hold_exp = exp_q[0];
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold", {10'd0, diff, bout, ovf, zero, out_tag}, {10'd0, hold_exp});
      end
      @(posedge clk);
      #1;
      if (took) begin
        rand_op(ra, rb, rbin);
        set_op(ra, rb, rbin, 4'(10 + c));
      end
    end
    @(negedge clk);
    chk("bp_accepts", acc_cnt - acc0, 32'd3);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    pop_cyc.delete();
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("bp_drain_count", pop_cyc.size(), 32'd3);

    // Reset with two operations in flight.
    drive_op(16'h4321, 16'h1111, 1'b0, 4'hA);
    drive_op(16'h0001, 16'h0002, 1'b0, 4'hB);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    pop_cyc.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_results", pop_cyc.size(), 32'd0);
    chk("no_stale_valid", {31'd0, out_valid}, 32'd0);

    // Random traffic with random backpressure.
    nops = 0;
    guard = 0;
    took = 1'b0;
    in_valid = 1'b0;
    while (nops < 10000 && guard < 60000) begin
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_op(ra, rb, rbin);
        a = ra; b = rb; bin = rbin; in_tag = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) nops++;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rand_ops_done", nops, 32'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
